// File: rtl/phys_reg_free_list.sv
// Free list of physical register tags. Tags are handed out in FIFO order and returned on retire.
// Tag 0 is the hardwired-zero register, so it never enters the list. A presence bitmap rejects double frees.
module phys_reg_free_list #(
    parameter int DIR_WIDTH  = 5,
    parameter int INIT_FIRST = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 alloc_req,
    output logic                 alloc_valid,
    output logic [DIR_WIDTH-1:0] alloc_tag,
    input  logic                 free_en,
    input  logic [DIR_WIDTH-1:0] free_tag,
    output logic [DIR_WIDTH-1:0] free_count,
    output logic                 free_err
);

    localparam int NUM_TAGS = 2 ** DIR_WIDTH;
    localparam int DEPTH    = NUM_TAGS - 1;
    localparam int INIT_CNT = NUM_TAGS - INIT_FIRST;

    logic [DIR_WIDTH-1:0] entry [0:DEPTH-1];
    logic [DIR_WIDTH-1:0] head;
    logic [DIR_WIDTH-1:0] tail;
    logic [DIR_WIDTH-1:0] count;
    logic [NUM_TAGS-1:0]  in_list;

    logic fire;
    logic free_ok;

    // Presence is checked against the pre-edge bitmap. A tag that is being
    // allocated in this same cycle is therefore still present, and a free of it is rejected.
    always_comb begin
        fire    = alloc_req && (count != '0);
        free_ok = free_en && (free_tag != '0) && !in_list[free_tag];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                entry[i] <= (i <= DEPTH - INIT_FIRST) ? DIR_WIDTH'(INIT_FIRST + i) : '0;
            end
            for (int t = 0; t < NUM_TAGS; t++) begin
                in_list[t] <= (t >= INIT_FIRST);
            end
            head     <= '0;
            tail     <= DIR_WIDTH'(INIT_CNT % DEPTH);
            count    <= DIR_WIDTH'(INIT_CNT);
            free_err <= 1'b0;
        end else begin
            if (fire) begin
                head               <= (head == DIR_WIDTH'(DEPTH - 1)) ? '0 : head + 1'b1;
                in_list[alloc_tag] <= 1'b0;
            end
            if (free_ok) begin
                entry[tail]       <= free_tag;
                tail              <= (tail == DIR_WIDTH'(DEPTH - 1)) ? '0 : tail + 1'b1;
                in_list[free_tag] <= 1'b1;
            end
            // The bitmap stops any free when the list is full, so count cannot overflow.
            if (free_ok && !fire) begin
                count <= count + 1'b1;
            end else if (fire && !free_ok) begin
                count <= count - 1'b1;
            end
            free_err <= free_en && !free_ok;
        end
    end

    assign alloc_valid = (count != '0);
    assign alloc_tag   = entry[head];
    assign free_count  = count;

endmodule
